ps2_keyboard_seg: RTL and testbench
===================================

Name: ps2_keyboard_seg

Overview:
PS/2 keyboard receiver with a built-in hex seven-segment driver for the last pressed key. It deserialises keyboard frames, tracks make/break codes and exposes the current scan code with a key-held flag. It also drives two active-low seven-segment digits showing that code in hex. The digits blank when no key is held. It sits between the board PS/2 pins and the display/ASCII-mapping logic.

Parameters:
TIMEOUT_CYCLES, 50000, clk cycles with no ps2_clk falling edge before a partial frame is discarded
SYNC_STAGES, 3, flip-flop stages used to synchronise ps2_clk and ps2_data (minimum 2)

Ports:
clk  input  1  system clock; all state is on its rising edge
rst  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock from the keyboard (asynchronous)
ps2_data  input  1  raw PS/2 data from the keyboard (asynchronous)
code  output  8  scan code of the last accepted make code
ready  output  1  1 while the key in code is held; 0 after its break or after reset
frame_err  output  1  one-cycle pulse when a complete frame fails its checks
seg_lo  output  8  active-low digit for code[3:0]; bit0=a .. bit6=g, bit7=dp
seg_hi  output  8  active-low digit for code[7:4]; same bit order

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset state:
  - code=0x00, ready=0, frame_err=0, break flag=0
  - bit counter=0, timeout counter=0, synchronisers filled with 1
  - seg_lo=seg_hi=0xFF (blank)
- Synchronisation: ps2_clk and ps2_data each pass through SYNC_STAGES flops. A falling edge is synchronised prev=1 and cur=0. Data is sampled on the cycle the falling edge is detected.
- Frame format: 11 bits, in this order:
  - start bit = 0
  - 8 data bits, LSB first
  - odd parity bit
  - stop bit = 1
- Bit counter counts 0..10 and shifts bits into an 11-bit buffer.
- On the 11th falling edge, the frame is validated in that same cycle:
  - start==0, stop==1, and XOR of the data bits and the parity bit == 1.
  - The counter then returns to 0.
- If the frame is valid, the byte is applied in the same cycle, so outputs update on the next clk edge:
  - 0xF0: set break flag; code and ready unchanged.
  - 0xE0: ignored, no state change.
  - Any other byte while break flag is 1: clear break flag, ready<=0, code unchanged.
  - Any other byte while break flag is 0: code<=byte, ready<=1. Typematic repeats of the same code leave the outputs stable.
- Invalid frame: byte discarded, frame_err=1 for exactly one cycle, no other state change.
- Timeout:
  - The timeout counter increments while the bit counter is non-zero and no falling edge occurs.
  - It clears on every falling edge.
  - When it reaches TIMEOUT_CYCLES, the bit counter and the counter itself clear. No frame_err is raised.
- Reset mid-frame discards the partial frame. The next falling edge is treated as a start bit.
- Seven-segment encoding is combinational from the registered code and ready. dp (bit7) is always 1.
  - ready=0: both digits 0xFF.
  - ready=1, nibble to encoded value (dp included):
    - 0:C0 1:F9 2:A4 3:B0
    - 4:99 5:92 6:82 7:F8
    - 8:80 9:90 A:88 b:83
    - C:C6 d:A1 E:86 F:8E
- No internal FIFO: a new make code overwrites code immediately.

Test Plan:
- Reset, then idle lines high for 100 cycles -> code=0x00, ready=0, frame_err=0, seg_lo=seg_hi=0xFF.
- Send a valid frame 0x1C (parity bit 0) -> code=0x1C, ready=1, seg_lo=0xC6, seg_hi=0xF9. Send 0x1C again -> no output change.
- Send F0 then 1C -> ready=0 after the second frame, code stays 0x1C, both segs 0xFF. Then send 0x45 -> code=0x45, ready=1, seg_lo=0x92, seg_hi=0x99.
- Send 0x16 with a wrong parity bit, and separately with stop=0 -> frame_err single-cycle pulse each time; code/ready unchanged. A following valid 0x16 -> code=0x16, seg_lo=0x82, seg_hi=0xF9.
- Send 4 bits, stall for more than TIMEOUT_CYCLES, then a full valid 0x3E frame -> code=0x3E, ready=1, no frame_err.
- Assert rst for one cycle mid-frame while ready=1 -> all outputs return to reset values; a subsequent valid 0x1E frame -> code=0x1E, ready=1.

Source files
------------

// File: rtl/ps2_keyboard_seg.sv
// PS/2 keyboard receiver: deserialises scan-code frames, tracks make/break state
// and drives two active-low hex seven-segment digits for the held key.
module ps2_keyboard_seg #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       ready,
    output logic       frame_err,
    output logic [7:0] seg_lo,
    output logic [7:0] seg_hi
);

    localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FRAME_W   = 11;
    localparam logic [7:0]  BREAK_PFX = 8'hF0;
    localparam logic [7:0]  EXT_PFX   = 8'hE0;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic [3:0]             bit_cnt;
    logic [FRAME_W-2:0]     shreg;
    logic [TW-1:0]          to_cnt;
    logic                   brk;

    logic                   clk_cur;
    logic                   data_cur;
    logic                   fall;
    logic [FRAME_W-1:0]     frame_c;
    logic                   frame_ok;
    logic [7:0]             frame_byte;
    logic                   timed_out;

    // Synchronised line values and falling-edge detect
    always_comb begin
        clk_cur    = clk_sync[SYNC_STAGES-1];
        data_cur   = data_sync[SYNC_STAGES-1];
        fall       = clk_prev & ~clk_cur;
        frame_c    = {data_cur, shreg};
        frame_byte = frame_c[8:1];
        frame_ok   = ~frame_c[0] & frame_c[10] & (^frame_c[9:1]);
        timed_out  = (to_cnt == TW'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_cur;
        end
    end

    // Frame deserialiser, timeout and make/break tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 4'd0;
            shreg     <= '0;
            to_cnt    <= '0;
            brk       <= 1'b0;
            code      <= 8'h00;
            ready     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                shreg  <= frame_c[FRAME_W-1:1];
                if (bit_cnt == 4'(FRAME_W - 1)) begin
                    bit_cnt <= 4'd0;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                    end else if (frame_byte == BREAK_PFX) begin
                        brk <= 1'b1;
                    end else if (frame_byte == EXT_PFX) begin
                        brk <= brk;
                    end else if (brk) begin
                        brk   <= 1'b0;
                        ready <= 1'b0;
                    end else begin
                        code  <= frame_byte;
                        ready <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (timed_out) begin
                    bit_cnt <= 4'd0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end
        end
    end

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Digits blank whenever no key is held
    always_comb begin
        seg_lo = 8'hFF;
        seg_hi = 8'hFF;
        if (ready) begin
            seg_lo = hex_seg(code[3:0]);
            seg_hi = hex_seg(code[7:4]);
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_seg.sv
// Bench for ps2_keyboard_seg: directed frames plus random make/break traffic
// checked every settled cycle against a frame-level model.
module tb_ps2_keyboard_seg;

    localparam int unsigned TO   = 200;
    localparam int unsigned HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       ready;
    logic       frame_err;
    logic [7:0] seg_lo;
    logic [7:0] seg_hi;

    always #5 clk = ~clk;

    ps2_keyboard_seg #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(3)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code(code), .ready(ready), .frame_err(frame_err),
        .seg_lo(seg_lo), .seg_hi(seg_hi)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int exp_err  = 0;
    bit settled  = 1'b0;
    logic err_prev = 1'b0;
    logic [7:0] m_code = 8'h00;
    bit m_rdy = 1'b0;
    bit m_brk = 1'b0;
    logic [7:0] seg_tab [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_seg(input bit r, input logic [3:0] n);
        return r ? seg_tab[n] : 8'hFF;
    endfunction

    // Frame-level model: apply one complete 11-bit frame as sent on the wire
    task automatic model_frame(input logic [10:0] f);
        logic [7:0] b;
        b = f[8:1];
        if (!(f[0] == 1'b0 && f[10] == 1'b1 && (^f[9:1]) == 1'b1)) exp_err++;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) begin end
        else if (m_brk) begin m_brk = 1'b0; m_rdy = 1'b0; end
        else begin m_code = b; m_rdy = 1'b1; end
    endtask

    // frame_err pulse counter; a pulse must last one cycle only
    always @(negedge clk) begin
        if (frame_err === 1'b1) begin
            err_cnt++;
            chk("err_single_cycle", 32'(err_prev), 32'd0);
        end
        err_prev = frame_err;
    end

    // Per-cycle comparison whenever no frame result is in flight
    always @(negedge clk) begin
        if (settled) begin
            chk("code", 32'(code), 32'(m_code));
            chk("ready", 32'(ready), 32'(m_rdy));
            chk("seg_lo", 32'(seg_lo), 32'(m_seg(m_rdy, m_code[3:0])));
            chk("seg_hi", 32'(seg_hi), 32'(m_seg(m_rdy, m_code[7:4])));
            chk("err_count", 32'(err_cnt), 32'(exp_err));
        end
    end

    task automatic ps2_bit(input logic b, input bit last);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        if (last) settled = 1'b0;
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                        input int nbits, input bit stall);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = (~^b) ^ bad_par;
        f[10]  = ~bad_stop;
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], i == 10);
        @(negedge clk) ps2_data = 1'b1;
        if (nbits == 11) begin
            repeat (4) @(negedge clk);
            model_frame(f);
            settled = 1'b1;
        end else if (stall) begin
            repeat (TO + 40) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        settled = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        m_code = 8'h00; m_rdy = 1'b0; m_brk = 1'b0;
        repeat (2) @(negedge clk);
        settled = 1'b1;
    endtask

    initial begin
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("reset_code", 32'(code), 32'h00);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_err", 32'(frame_err), 32'd0);
        chk("reset_seg_lo", 32'(seg_lo), 32'hFF);
        chk("reset_seg_hi", 32'(seg_hi), 32'hFF);
        settled = 1'b1;

        send(8'h1C, 0, 0, 11, 0);
        chk("make1c_code", 32'(code), 32'h1C);
        chk("make1c_ready", 32'(ready), 32'd1);
        chk("make1c_seg_lo", 32'(seg_lo), 32'hC6);
        chk("make1c_seg_hi", 32'(seg_hi), 32'hF9);
        send(8'h1C, 0, 0, 11, 0);
        chk("repeat_code", 32'(code), 32'h1C);

        send(8'hF0, 0, 0, 11, 0);
        chk("f0_ready_held", 32'(ready), 32'd1);
        send(8'h1C, 0, 0, 11, 0);
        chk("break_ready", 32'(ready), 32'd0);
        chk("break_code", 32'(code), 32'h1C);
        chk("break_seg_lo", 32'(seg_lo), 32'hFF);
        chk("break_seg_hi", 32'(seg_hi), 32'hFF);
        send(8'h45, 0, 0, 11, 0);
        chk("make45_seg_lo", 32'(seg_lo), 32'h92);
        chk("make45_seg_hi", 32'(seg_hi), 32'h99);

        send(8'h16, 1, 0, 11, 0);
        chk("badpar_err_total", 32'(err_cnt), 32'd1);
        chk("badpar_code", 32'(code), 32'h45);
        send(8'h16, 0, 1, 11, 0);
        chk("badstop_err_total", 32'(err_cnt), 32'd2);
        send(8'h16, 0, 0, 11, 0);
        chk("make16_code", 32'(code), 32'h16);
        chk("make16_seg_lo", 32'(seg_lo), 32'h82);
        chk("make16_seg_hi", 32'(seg_hi), 32'hF9);

        send(8'h3E, 0, 0, 4, 1);
        send(8'h3E, 0, 0, 11, 0);
        chk("timeout_code", 32'(code), 32'h3E);
        chk("timeout_ready", 32'(ready), 32'd1);
        chk("timeout_no_err", 32'(err_cnt), 32'd2);

        send(8'h55, 0, 0, 5, 0);
        do_reset();
        chk("midrst_code", 32'(code), 32'h00);
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_seg_lo", 32'(seg_lo), 32'hFF);
        send(8'h1E, 0, 0, 11, 0);
        chk("after_rst_code", 32'(code), 32'h1E);
        chk("after_rst_ready", 32'(ready), 32'd1);

        // Random make/break/extended traffic with corruption and truncation
        for (int k = 0; k < 80; k++) begin
            logic [7:0] b;
            int sel;
            sel = int'($urandom_range(0, 7));
            if (sel < 2) b = 8'hF0;
            else if (sel == 2) b = 8'hE0;
            else b = 8'($urandom);
            sel = int'($urandom_range(0, 11));
            if (sel == 0) send(b, 1, 0, 11, 0);
            else if (sel == 1) send(b, 0, 1, 11, 0);
            else if (sel == 2) send(b, 0, 0, int'($urandom_range(1, 10)), 1);
            else send(b, 0, 0, 11, 0);
        end

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
